wb_cpu_bus_arbiter: RTL and testbench

Parametrised Wishbone B3 arbiter that merges NUM_MASTERS CPU-side master ports (instruction bus, data bus, debug or DMA masters) onto one shared master port toward the SoC interconnect. It sits directly behind the CPU wrapper, so single-port interconnects can host any supported core. It adds round-robin or fixed-priority arbitration, burst/cycle locking, and a bus-timeout watchdog that terminates hung transfers with an error.

---
 rtl/wb_cpu_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_cpu_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_bus_arbiter.sv
// Wishbone B3 N:1 CPU-side bus arbiter.
// Round-robin or fixed priority, cycle locking, bus-timeout watchdog.
module wb_cpu_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS*3-1:0]              m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]              m_bte_i,
  output logic [DATA_WIDTH-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [NUM_MASTERS-1:0]                m_rty_o,
  output logic [ADDRESS_WIDTH-1:0]              s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  output logic                                  s_we_o,
  output logic                                  s_stb_o,
  output logic                                  s_cyc_o,
  output logic [2:0]                            s_cti_o,
  output logic [1:0]                            s_bte_o,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  input  logic                                  s_ack_i,
  input  logic                                  s_err_i,
  input  logic                                  s_rty_i,
  output logic [NUM_MASTERS-1:0]                grant_o,
  output logic                                  timeout_o
);

  localparam int NM = NUM_MASTERS;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e        state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [WW-1:0] wd_q, wd_d;

  logic          owned;
  logic          g_cyc;
  logic          g_stb;
  logic          term;
  logic          fire;
  logic [IW-1:0] base;
  logic [IW-1:0] cand;
  logic [IW-1:0] win_idx;
  logic          win_any;
  logic [IW-1:0] nxt_ptr;

  assign owned = (state_q == OWNED);
  assign g_cyc = |(grant_q & m_cyc_i);
  assign g_stb = |(grant_q & m_stb_i);
  assign term  = s_ack_i | s_err_i | s_rty_i;
  assign base  = (PRIORITY_MODE == 0) ? rr_ptr_q : '0;

  // Walk the search order backwards so the earliest candidate wins.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    cand    = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      cand = IW'((int'(base) + i) % NM);
      if (m_cyc_i[cand]) begin
        win_idx = cand;
        win_any = 1'b1;
      end
    end
  end

  assign nxt_ptr = (gidx_q == IW'(NM - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d          = OWNED;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
        end
      end
      OWNED: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          if (PRIORITY_MODE == 0) rr_ptr_d = nxt_ptr;
        end
      end
    endcase
  end

  always_comb begin
    fire = 1'b0;
    wd_d = '0;
    if (TIMEOUT_CYCLES > 0) begin
      fire = owned && g_stb && (wd_q == WW'(TIMEOUT_CYCLES));
      if (owned && g_stb && !term && !fire) wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int k = 0; k < NM; k++) begin
      s_adr_o |= {AW{grant_q[k]}} & m_adr_i[k*AW +: AW];
      s_dat_o |= {DW{grant_q[k]}} & m_dat_i[k*DW +: DW];
      s_sel_o |= {SW{grant_q[k]}} & m_sel_i[k*SW +: SW];
      s_we_o  |= grant_q[k] & m_we_i[k];
      s_cti_o |= {3{grant_q[k]}} & m_cti_i[k*3 +: 3];
      s_bte_o |= {2{grant_q[k]}} & m_bte_i[k*2 +: 2];
    end
  end

  // A firing watchdog kills the strobe and turns any late ack into err.
  assign s_stb_o   = g_stb & ~fire;
  assign s_cyc_o   = g_cyc & ~fire;
  assign m_ack_o   = grant_q & {NM{s_ack_i & ~fire}};
  assign m_err_o   = grant_q & {NM{s_err_i | fire}};
  assign m_rty_o   = grant_q & {NM{s_rty_i & ~fire}};
  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = fire;

endmodule

// File: tb/tb_wb_cpu_bus_arbiter.sv
// Directed bench for wb_cpu_bus_arbiter.
// Round-robin and fixed-priority instances share one stimulus.
module tb_wb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] m_adr, m_dat;
  logic [7:0]  m_sel;
  logic [1:0]  m_we, m_stb, m_cyc;
  logic [5:0]  m_cti;
  logic [3:0]  m_bte;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;

  logic [31:0] rr_mdat, rr_sadr, rr_sdat;
  logic [1:0]  rr_ack, rr_err, rr_rty, rr_grant, rr_sbte;
  logic [3:0]  rr_ssel;
  logic [2:0]  rr_scti;
  logic        rr_swe, rr_sstb, rr_scyc, rr_to;

  logic [31:0] fp_mdat, fp_sadr, fp_sdat;
  logic [1:0]  fp_ack, fp_err, fp_rty, fp_grant, fp_sbte;
  logic [3:0]  fp_ssel;
  logic [2:0]  fp_scti;
  logic        fp_swe, fp_sstb, fp_scyc, fp_to;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_cpu_bus_arbiter #(
    .NUM_MASTERS(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)
  ) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(rr_mdat), .m_ack_o(rr_ack),
    .m_err_o(rr_err), .m_rty_o(rr_rty),
    .s_adr_o(rr_sadr), .s_dat_o(rr_sdat), .s_sel_o(rr_ssel),
    .s_we_o(rr_swe), .s_stb_o(rr_sstb), .s_cyc_o(rr_scyc),
    .s_cti_o(rr_scti), .s_bte_o(rr_sbte),
    .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(rr_grant), .timeout_o(rr_to)
  );

  wb_cpu_bus_arbiter #(
    .NUM_MASTERS(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)
  ) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(fp_mdat), .m_ack_o(fp_ack),
    .m_err_o(fp_err), .m_rty_o(fp_rty),
    .s_adr_o(fp_sadr), .s_dat_o(fp_sdat), .s_sel_o(fp_ssel),
    .s_we_o(fp_swe), .s_stb_o(fp_sstb), .s_cyc_o(fp_scyc),
    .s_cti_o(fp_scti), .s_bte_o(fp_sbte),
    .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(fp_grant), .timeout_o(fp_to)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_adr = '0; m_dat = '0; m_sel = '0;
    m_we  = '0; m_stb = '0; m_cyc = '0;
    m_cti = '0; m_bte = '0;
    s_dat = '0; s_ack = 1'b0;
    s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  // One single-beat ownership by the master in g, then its drop
  // cycle, then the mandatory idle cycle with both requesting again.
  task automatic handoff(input bit fp, input logic [1:0] g,
                         input logic [1:0] req_next);
    tick();
    chk("grant", fp ? fp_grant : rr_grant, g);
    s_ack = 1'b1;
    #1;
    chk("ack", fp ? fp_ack : rr_ack, g);
    tick();
    m_cyc = ~g;
    m_stb = ~g;
    s_ack = 1'b0;
    #1;
    chk("grant_hold", fp ? fp_grant : rr_grant, g);
    tick();
    m_cyc = req_next;
    m_stb = req_next;
    #1;
    chk("idle_gap", fp ? fp_grant : rr_grant, 2'b00);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    s_ack = 1'b1;
    #2;
    chk("rst_grant", rr_grant, 2'b00);
    chk("rst_scyc", rr_scyc, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_grant_clk", rr_grant, 2'b00);
    chk("rst_ack", rr_ack, 2'b00);
    chk("rst_to", rr_to, 1'b0);
    chk("rst_fp_sstb", fp_sstb, 1'b0);

    // Single master read
    do_reset();
    m_adr[31:0] = 32'h0000_1000;
    m_cyc = 2'b01;
    m_stb = 2'b01;
    #1;
    chk("t1_pre_grant", rr_grant, 2'b00);
    tick();
    chk("t1_grant", rr_grant, 2'b01);
    chk("t1_sadr", rr_sadr, 32'h0000_1000);
    chk("t1_scyc", rr_scyc, 1'b1);
    chk("t1_swe", rr_swe, 1'b0);
    tick();
    chk("t1_wait_ack", rr_ack, 2'b00);
    tick();
    s_ack = 1'b1;
    s_dat = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack", rr_ack, 2'b01);
    chk("t1_mdat", rr_mdat, 32'hDEAD_BEEF);
    tick();
    s_ack = 1'b0;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    #1;
    chk("t1_release_hold", rr_grant, 2'b01);
    tick();
    chk("t1_idle", rr_grant, 2'b00);
    chk("t1_idle_scyc", rr_scyc, 1'b0);

    // Round-robin alternation
    do_reset();
    m_cyc = 2'b11;
    m_stb = 2'b11;
    handoff(1'b0, 2'b01, 2'b11);
    handoff(1'b0, 2'b10, 2'b11);
    handoff(1'b0, 2'b01, 2'b11);
    handoff(1'b0, 2'b10, 2'b00);

    // Fixed priority: master 0 keeps winning, then yields
    do_reset();
    m_cyc = 2'b11;
    m_stb = 2'b11;
    handoff(1'b1, 2'b01, 2'b11);
    handoff(1'b1, 2'b01, 2'b11);
    handoff(1'b1, 2'b01, 2'b10);
    tick();
    chk("fp_m1_grant", fp_grant, 2'b10);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();

    // Burst lock
    do_reset();
    m_adr[63:32] = 32'h0000_2000;
    m_cti[5:3] = 3'b010;
    m_cyc = 2'b10;
    m_stb = 2'b10;
    tick();
    m_adr[31:0] = 32'h0000_3000;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    for (int b = 0; b < 4; b++) begin
      m_adr[63:32] = 32'h0000_2000 + 32'(4 * b);
      m_cti[5:3] = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1'b1;
      #1;
      chk("burst_grant", rr_grant, 2'b10);
      chk("burst_ack", rr_ack, 2'b10);
      chk("burst_sadr", rr_sadr, 32'h0000_2000 + 32'(4 * b));
      chk("burst_scti", rr_scti, (b == 3) ? 3'b111 : 3'b010);
      tick();
    end
    s_ack = 1'b0;
    m_cyc = 2'b01;
    m_stb = 2'b01;
    #1;
    chk("burst_drop_hold", rr_grant, 2'b10);
    tick();
    chk("burst_gap", rr_grant, 2'b00);
    tick();
    chk("burst_m0_grant", rr_grant, 2'b01);
    chk("burst_m0_sadr", rr_sadr, 32'h0000_3000);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();

    // Watchdog with a late ack on the firing cycle
    do_reset();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    for (int c = 1; c < 9; c++) begin
      chk("wd_quiet", rr_to, 1'b0);
      chk("wd_sstb", rr_sstb, 1'b1);
      tick();
    end
    s_ack = 1'b1;
    #1;
    chk("wd_to", rr_to, 1'b1);
    chk("wd_err", rr_err, 2'b01);
    chk("wd_ack_sup", rr_ack, 2'b00);
    chk("wd_sstb_kill", rr_sstb, 1'b0);
    chk("wd_scyc_kill", rr_scyc, 1'b0);
    chk("wd_fp_to", fp_to, 1'b1);
    tick();
    s_ack = 1'b0;
    #1;
    chk("wd_after", rr_to, 1'b0);
    chk("wd_after_err", rr_err, 2'b00);
    chk("wd_after_sstb", rr_sstb, 1'b1);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();

    // Reset abort; rr pointer is 1 here before the reset
    m_adr[63:32] = 32'h0000_4000;
    m_cti[5:3] = 3'b010;
    m_cyc = 2'b10;
    m_stb = 2'b10;
    tick();
    chk("abort_grant", rr_grant, 2'b10);
    s_ack = 1'b1;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_grant0", rr_grant, 2'b00);
    chk("abort_scyc", rr_scyc, 1'b0);
    chk("abort_sstb", rr_sstb, 1'b0);
    chk("abort_sadr", rr_sadr, 32'h0);
    chk("abort_ack", rr_ack, 2'b00);
    m_cti = '0;
    s_ack = 1'b0;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    #3;
    rst_n = 1'b1;
    tick();
    chk("abort_tie_rr", rr_grant, 2'b01);
    chk("abort_tie_fp", fp_grant, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
